// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// uart_boot_loader_if: UART byte stream in, single-entry RAM write port and boot status out.
// master = boot loader side, slave = UART receiver / interconnect / SoC side.
interface uart_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_reset;
  logic [31:0] boot_addr;
  logic        boot_done;
  logic        boot_err;

  modport master (
    input  rx_valid, rx_data, mem_gnt,
    output mem_req, mem_addr, mem_wdata, mem_wstrb,
    output cpu_reset, boot_addr, boot_done, boot_err
  );

  modport slave (
    output rx_valid, rx_data, mem_gnt,
    input  mem_req, mem_addr, mem_wdata, mem_wstrb,
    input  cpu_reset, boot_addr, boot_done, boot_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// uart_boot_loader: loads a LEN/ADDR-headed image from the UART byte stream into RAM, then releases the CPU.
// BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the image data.
module uart_boot_loader #(
  parameter logic [31:0] RESET_ADDR = 32'h0001_0000
) (
  input  logic               g_clk,
  input  logic               g_reset,
  uart_boot_loader_if.master bus
);
  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_TAIL  = S_CSUM;
`else
  localparam logic [2:0] S_TAIL  = S_FLUSH;
`endif

  logic [2:0]  state;
  logic [1:0]  hdr_cnt;
  logic [31:0] len;
  logic [31:0] hdr_addr;
  logic [31:0] remaining;
  logic [31:0] wr_addr;
  logic [31:0] asm_data;
  logic [3:0]  asm_strb;
  logic [1:0]  byte_idx;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic [31:0] addr_next;
  logic [31:0] word_next;
  logic [3:0]  strb_next;
  logic        word_full;
  logic        slot_free;
  logic        granted;

  always_comb begin
    addr_next = {hdr_addr[23:0], bus.rx_data};
    word_next = asm_data;
    word_next[{byte_idx, 3'b000} +: 8] = bus.rx_data;
    strb_next = asm_strb | (4'b0001 << byte_idx);
    word_full = (byte_idx == 2'd3) || (remaining == 32'd1);
    granted   = bus.mem_req && bus.mem_gnt;
    // A grant this cycle frees the slot, so a word completing now can take it.
    slot_free = !bus.mem_req || bus.mem_gnt;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state         <= S_LEN;
      hdr_cnt       <= 2'd0;
      len           <= 32'd0;
      hdr_addr      <= 32'd0;
      remaining     <= 32'd0;
      wr_addr       <= 32'd0;
      asm_data      <= 32'd0;
      asm_strb      <= 4'd0;
      byte_idx      <= 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum          <= 8'd0;
`endif
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_wstrb <= 4'd0;
      bus.cpu_reset <= 1'b1;
      bus.boot_addr <= 32'd0;
      bus.boot_done <= 1'b0;
      bus.boot_err  <= 1'b0;
    end else begin
      if (granted) bus.mem_req <= 1'b0;
      case (state)
        S_LEN: if (bus.rx_valid) begin
          len     <= {len[23:0], bus.rx_data};
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd3) state <= S_ADDR;
        end
        S_ADDR: if (bus.rx_valid) begin
          hdr_addr <= addr_next;
          hdr_cnt  <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd3) begin
            if (addr_next[1:0] != 2'b00) bus.boot_err <= 1'b1;
            hdr_addr  <= {addr_next[31:2], 2'b00};
            wr_addr   <= {addr_next[31:2], 2'b00};
            remaining <= len;
            byte_idx  <= 2'd0;
            asm_data  <= 32'd0;
            asm_strb  <= 4'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            state     <= (len == 32'd0) ? S_TAIL : S_DATA;
          end
        end
        S_DATA: if (bus.rx_valid) begin
          remaining <= remaining - 32'd1;
          byte_idx  <= byte_idx + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum      <= csum ^ bus.rx_data;
`endif
          if (word_full) begin
            asm_data <= 32'd0;
            asm_strb <= 4'd0;
            wr_addr  <= wr_addr + 32'd4;
            if (slot_free) begin
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= wr_addr;
              bus.mem_wdata <= word_next;
              bus.mem_wstrb <= strb_next;
            end else begin
              bus.boot_err  <= 1'b1;
            end
          end else begin
            asm_data <= word_next;
            asm_strb <= strb_next;
          end
          if (remaining == 32'd1) state <= S_TAIL;
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: if (bus.rx_valid) begin
          if (bus.rx_data != csum) bus.boot_err <= 1'b1;
          state <= S_FLUSH;
        end
`endif
        S_FLUSH: if (slot_free) begin
          state         <= S_DONE;
          bus.cpu_reset <= 1'b0;
          bus.boot_done <= 1'b1;
          bus.boot_addr <= (len == 32'd0) ? RESET_ADDR : hdr_addr;
        end
        S_DONE: ;
        default: state <= S_LEN;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// tb_uart_boot_loader: randomized stimulus for uart_boot_loader checked against a byte-list image model.
module tb_uart_boot_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_boot_loader_if bus_if();
  uart_boot_loader #(.RESET_ADDR(32'h0001_0000)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gnt_cyc = -1;
  int rel_cyc = -1;
  int gnt_mode = 1;
  int stall = 0;
  logic [7:0]  img[$];
  logic [67:0] got_q[$];
  logic [67:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Grant driver: 0 = stalled, 1 = always granted, 2 = random with a short stall cap.
  always @(posedge clk) begin
    #1;
    if (gnt_mode == 0) bus_if.mem_gnt = 1'b0;
    else if (gnt_mode == 1) bus_if.mem_gnt = 1'b1;
    else begin
      if (bus_if.mem_req) stall++; else stall = 0;
      bus_if.mem_gnt = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus_if.mem_gnt) stall = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.mem_req && bus_if.mem_gnt) begin
        got_q.push_back({bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb});
        last_gnt_cyc = cyc;
      end
      if (!bus_if.cpu_reset && rel_cyc < 0) rel_cyc = cyc;
    end
  end

  // Reference image model: little-endian words from the byte list, partial strobe on a short tail.
  task automatic build_exp(input logic [31:0] addr);
    exp_q.delete();
    for (int w = 0; w * 4 < img.size(); w++) begin
      logic [31:0] d = 32'd0;
      logic [3:0]  s = 4'd0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < img.size()) begin
          d = d | (32'(img[w * 4 + k]) << (8 * k));
          s = s | (4'b0001 << k);
        end
      exp_q.push_back({(addr & 32'hFFFF_FFFC) + 32'(4 * w), d, s});
    end
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    got_q.delete();
    rel_cyc = -1;
    last_gnt_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    @(posedge clk); #1;
    bus_if.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i * 8 +: 8], $urandom_range(0, 2));
  endtask

  task automatic send_load(input logic [31:0] addr, input int csum);
    logic [7:0] x = 8'h00;
    send_word(32'(img.size()));
    send_word(addr);
    for (int i = 0; i < img.size(); i++) begin
      x = x ^ img[i];
      send_byte(img[i], $urandom_range(0, 2));
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte((csum < 0) ? x : 8'(csum), 1);
`else
    if (csum > 255) x = 8'h00;
`endif
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus_if.boot_done) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req got %b exp 0", bus_if.mem_req); end
    checks++; if (bus_if.mem_addr !== 32'd0) begin errors++; $display("FAIL reset mem_addr got %h exp 0", bus_if.mem_addr); end
    checks++; if (bus_if.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset mem_wdata got %h exp 0", bus_if.mem_wdata); end
    checks++; if (bus_if.mem_wstrb !== 4'd0) begin errors++; $display("FAIL reset mem_wstrb got %h exp 0", bus_if.mem_wstrb); end
    checks++; if (bus_if.cpu_reset !== 1'b1) begin errors++; $display("FAIL reset cpu_reset got %b exp 1", bus_if.cpu_reset); end
    checks++; if (bus_if.boot_addr !== 32'd0) begin errors++; $display("FAIL reset boot_addr got %h exp 0", bus_if.boot_addr); end
    checks++; if (bus_if.boot_done !== 1'b0) begin errors++; $display("FAIL reset boot_done got %b exp 0", bus_if.boot_done); end
    checks++; if (bus_if.boot_err !== 1'b0) begin errors++; $display("FAIL reset boot_err got %b exp 0", bus_if.boot_err); end
  endtask

  task automatic test_load(input string name, input int n, input logic [31:0] addr, input int mode);
    bit ok;
    do_reset();
    gnt_mode = mode;
    if (n >= 0) fill_img(n);
    build_exp(addr);
    send_load(addr, -1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s done_timeout boot_done got 0 exp 1", name); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s write_count got %0d exp %0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [67:0] g = (i < got_q.size()) ? got_q[i] : 68'bx;
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL %s write%0d got %h exp %h", name, i, g, exp_q[i]); end
    end
    checks++; if (bus_if.boot_addr !== ((img.size() == 0) ? 32'h0001_0000 : (addr & 32'hFFFF_FFFC))) begin
      errors++; $display("FAIL %s boot_addr got %h", name, bus_if.boot_addr); end
    checks++; if (bus_if.boot_err !== (addr[1:0] != 2'b00)) begin errors++; $display("FAIL %s boot_err got %b exp %b", name, bus_if.boot_err, addr[1:0] != 2'b00); end
    checks++; if (bus_if.cpu_reset !== 1'b0) begin errors++; $display("FAIL %s cpu_reset got %b exp 0", name, bus_if.cpu_reset); end
  endtask

  task automatic test_main;
    test_load("main", 112, 32'h0001_0000, 1);
`ifndef BOOT_LOADER_CHECKSUM_EN
    checks++; if (rel_cyc !== last_gnt_cyc + 1) begin errors++; $display("FAIL main cpu_reset_fall got cyc %0d exp %0d", rel_cyc, last_gnt_cyc + 1); end
`endif
  endtask

  task automatic test_short;
    img.delete();
    img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33);
    img.push_back(8'h44); img.push_back(8'h55);
    test_load("short", -1, 32'h0000_2000, 2);
    checks++; if (exp_q.size() != 2 || exp_q[1] !== {32'h2004, 32'h0000_0055, 4'h1}) begin
      errors++; $display("FAIL short model_tail got %h exp %h", exp_q[exp_q.size() - 1], {32'h2004, 32'h0000_0055, 4'h1}); end
  endtask

  task automatic test_len0;
    test_load("len0", 0, 32'h1234_5678, 1);
  endtask

  task automatic test_misalign;
    test_load("misalign", 4, 32'h0000_6003, 1);
  endtask

  task automatic test_overrun;
    bit ok;
    do_reset();
    gnt_mode = 0;
    fill_img(12);
    build_exp(32'h0000_3000);
    send_load(32'h0000_3000, -1);
    repeat (20) @(negedge clk);
    checks++; if (bus_if.mem_req !== 1'b1) begin errors++; $display("FAIL overrun pending_req got %b exp 1", bus_if.mem_req); end
    checks++; if (bus_if.mem_addr !== 32'h3000) begin errors++; $display("FAIL overrun pending_addr got %h exp 3000", bus_if.mem_addr); end
    checks++; if (bus_if.boot_err !== 1'b1) begin errors++; $display("FAIL overrun boot_err got %b exp 1", bus_if.boot_err); end
    checks++; if (bus_if.boot_done !== 1'b0) begin errors++; $display("FAIL overrun early_done got %b exp 0", bus_if.boot_done); end
    gnt_mode = 1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun done_timeout boot_done got 0 exp 1"); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL overrun write_count got %0d exp 1", got_q.size()); end
    checks++; if (((got_q.size() > 0) ? got_q[0] : 68'bx) !== exp_q[0]) begin errors++; $display("FAIL overrun word0 got %h exp %h", (got_q.size() > 0) ? got_q[0] : 68'bx, exp_q[0]); end
  endtask

  task automatic test_reset_mid;
    gnt_mode = 1;
    do_reset();
    send_word(32'd8);
    send_word(32'h0000_4000);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.cpu_reset !== 1'b1 || bus_if.mem_req !== 1'b0 || bus_if.boot_err !== 1'b0 || bus_if.mem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_mid outputs got cpu_reset=%b mem_req=%b err=%b addr=%h", bus_if.cpu_reset, bus_if.mem_req, bus_if.boot_err, bus_if.mem_addr); end
    #1 rst = 1'b0;
    got_q.delete();
    rel_cyc = -1;
    fill_img(4);
    build_exp(32'h0000_5000);
    send_load(32'h0000_5000, -1);
    repeat (10) @(negedge clk);
    checks++; if (bus_if.boot_done !== 1'b1) begin errors++; $display("FAIL reset_mid boot_done got %b exp 1", bus_if.boot_done); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL reset_mid word got %h exp %h", (got_q.size() > 0) ? got_q[0] : 68'bx, exp_q[0]); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++)
      test_load("random", $urandom_range(1, 33), {14'd0, 16'($urandom), 2'b00}, 2);
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      gnt_mode = 1;
      img.delete(); img.push_back(8'hA5); img.push_back(8'h0F);
      send_load(32'h0000_7000, (pass == 0) ? 8'hAA : 8'h00);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL checksum%0d done got 0 exp 1", pass); end
      checks++; if (bus_if.boot_err !== (pass == 1)) begin errors++; $display("FAIL checksum%0d boot_err got %b exp %b", pass, bus_if.boot_err, pass == 1); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    test_reset();
    test_main();
    test_short();
    test_len0();
    test_misalign();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
